// File: rtl/mops_test_sequencer.sv
// Stimulus sequencer for MOPSHUB hub tests: walks CAN buses issuing SDO read requests,
// judges each response, counts errors and provides a free-running MOPS clock-enable tick.
module mops_test_sequencer #(
  parameter int DIV         = 4,
  parameter int ADC_CH_LAST = 7,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  n_buses,
  input  logic        start_data_gen,
  input  logic        ext_rst_mops,
  input  logic        test_rx,
  input  logic        test_tx,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [75:0] frame_data,
  input  logic        resp_valid,
  input  logic [75:0] resp_data,
  input  logic [4:0]  can_rec_select,
  output logic [7:0]  bus_id,
  output logic [5:0]  adc_ch,
  output logic        test_rx_start,
  output logic        test_rx_end,
  output logic        test_tx_start,
  output logic        test_tx_end,
  output logic [7:0]  err_cnt,
  output logic        tick_mops
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, START, SEND, WAIT, NEXT, DONE} state_t;

  state_t        r_state;
  logic          r_armed;
  logic          r_modeRx;
  logic [4:0]    r_nBuses;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_divCnt;
  logic          r_tick;
  logic          r_frameValid;
  logic [75:0]   r_frameData;
  logic [7:0]    r_busId;
  logic [5:0]    r_adcCh;
  logic [7:0]    r_errCnt;
  logic          r_rxStart, r_rxEnd, r_txStart, r_txEnd;

  logic w_respPass;
  logic w_moreCh;
  logic w_moreBus;
  logic w_timeout;
  logic w_unused;

  // RX frames read ADC subindex ch+1 of object 0x2400; TX frames read device type 0x1000.
  function automatic logic [75:0] buildFrame(input logic modeRx, input logic [7:0] bus,
                                             input logic [5:0] ch);
    logic [63:0] payload;
    if (modeRx) payload = {8'h40, 8'h00, 8'h24, {2'b00, ch} + 8'd1, 32'h0};
    else        payload = {8'h40, 8'h00, 8'h10, 40'h0};
    return {bus, 4'd8, payload};
  endfunction

  assign w_respPass = (resp_data[75:68] == r_busId) && (resp_data[63:56] == 8'h43) &&
                      (can_rec_select == r_busId[4:0]);
  assign w_moreCh   = r_modeRx && (r_adcCh < 6'(ADC_CH_LAST));
  assign w_moreBus  = r_busId < {3'b000, r_nBuses};
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
  assign w_unused   = &{1'b0, resp_data[67:64], resp_data[55:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (ext_rst_mops) begin
      r_armed <= 1'b0;
    end else if (start_data_gen) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
      r_tick   <= 1'b0;
    end else if (r_divCnt == DW'(DIV - 1)) begin
      r_divCnt <= '0;
      r_tick   <= 1'b1;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
      r_tick   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_modeRx     <= 1'b0;
      r_nBuses     <= '0;
      r_timer      <= '0;
      r_frameValid <= 1'b0;
      r_frameData  <= '0;
      r_busId      <= '0;
      r_adcCh      <= '0;
      r_errCnt     <= '0;
      r_rxStart    <= 1'b0;
      r_rxEnd      <= 1'b0;
      r_txStart    <= 1'b0;
      r_txEnd      <= 1'b0;
    end else begin
      r_rxStart <= 1'b0;
      r_rxEnd   <= 1'b0;
      r_txStart <= 1'b0;
      r_txEnd   <= 1'b0;
      if (ext_rst_mops) begin
        r_state      <= IDLE;
        r_frameValid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_armed && (test_rx || test_tx)) begin
              r_modeRx  <= test_rx;
              r_nBuses  <= n_buses;
              r_busId   <= '0;
              r_adcCh   <= '0;
              r_rxStart <= test_rx;
              r_txStart <= !test_rx;
              r_state   <= START;
            end
          end
          START: begin
            r_frameValid <= 1'b1;
            r_frameData  <= buildFrame(r_modeRx, r_busId, r_adcCh);
            r_state      <= SEND;
          end
          SEND: begin
            if (frame_ready) begin
              r_frameValid <= 1'b0;
              r_timer      <= '0;
              r_state      <= WAIT;
            end
          end
          WAIT: begin
            // A response arriving on the timeout cycle is still judged on its contents.
            if (resp_valid || w_timeout) begin
              if (!(resp_valid && w_respPass) && (r_errCnt != 8'hFF)) begin
                r_errCnt <= r_errCnt + 8'd1;
              end
              r_state <= NEXT;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          NEXT: begin
            if (w_moreCh) begin
              r_adcCh      <= r_adcCh + 6'd1;
              r_frameValid <= 1'b1;
              r_frameData  <= buildFrame(r_modeRx, r_busId, r_adcCh + 6'd1);
              r_state      <= SEND;
            end else begin
              r_adcCh <= '0;
              if (w_moreBus) begin
                r_busId   <= r_busId + 8'd1;
                r_rxStart <= r_modeRx;
                r_txStart <= !r_modeRx;
                r_state   <= START;
              end else begin
                r_rxEnd <= r_modeRx;
                r_txEnd <= !r_modeRx;
                r_state <= DONE;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign frame_valid   = r_frameValid;
  assign frame_data    = r_frameData;
  assign bus_id        = r_busId;
  assign adc_ch        = r_adcCh;
  assign test_rx_start = r_rxStart;
  assign test_rx_end   = r_rxEnd;
  assign test_tx_start = r_txStart;
  assign test_tx_end   = r_txEnd;
  assign err_cnt       = r_errCnt;
  assign tick_mops     = r_tick;

endmodule

// File: tb/tb_mops_test_sequencer.sv
// Self-checking bench for mops_test_sequencer: a transaction-level model predicts each
// request frame, pass timing, pulse counts and the saturating error count.
module tb_mops_test_sequencer;

  localparam int DIV  = 4;
  localparam int LAST = 1;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  n_buses = '0;
  logic        start_data_gen = 1'b0;
  logic        ext_rst_mops = 1'b0;
  logic        test_rx = 1'b0;
  logic        test_tx = 1'b0;
  logic        frame_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [75:0] resp_data = '0;
  logic [4:0]  can_rec_select = '0;
  logic        frame_valid;
  logic [75:0] frame_data;
  logic [7:0]  bus_id;
  logic [5:0]  adc_ch;
  logic        test_rx_start, test_rx_end, test_tx_start, test_tx_end;
  logic [7:0]  err_cnt;
  logic        tick_mops;

  int tests = 0;
  int fails = 0;
  int expErr = 0;
  int fvCnt = 0, rxS = 0, rxE = 0, txS = 0, txE = 0;

  mops_test_sequencer #(.DIV(DIV), .ADC_CH_LAST(LAST), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .n_buses(n_buses), .start_data_gen(start_data_gen),
    .ext_rst_mops(ext_rst_mops), .test_rx(test_rx), .test_tx(test_tx),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .can_rec_select(can_rec_select),
    .bus_id(bus_id), .adc_ch(adc_ch), .test_rx_start(test_rx_start),
    .test_rx_end(test_rx_end), .test_tx_start(test_tx_start), .test_tx_end(test_tx_end),
    .err_cnt(err_cnt), .tick_mops(tick_mops)
  );

  always #5 clk = ~clk;

  // Pulse and valid-cycle tallies, sampled mid-cycle so they never race the stimulus.
  always @(negedge clk) begin
    if (frame_valid)   fvCnt++;
    if (test_rx_start) rxS++;
    if (test_rx_end)   rxE++;
    if (test_tx_start) txS++;
    if (test_tx_end)   txE++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] expFrame(input bit rx, input int b, input int c);
    logic [63:0] p;
    if (rx) p = {8'h40, 8'h00, 8'h24, 8'(c + 1), 32'h0};
    else    p = {8'h40, 8'h00, 8'h10, 40'h0};
    return {8'(b), 4'd8, p};
  endfunction

  task automatic waitValid(input string tag);
    int i;
    i = 0;
    while (!frame_valid && i < 200) begin
      step();
      i++;
    end
    checkOutput(tag, 76'(frame_valid), 76'(1));
  endtask

  task automatic armPulse();
    start_data_gen = 1'b1;
    step();
    start_data_gen = 1'b0;
  endtask

  // One full pass; style 0 = good responses after 3 cycles, 1 = random, 2 = no responder.
  task automatic applyStimulus(input bit rx, input int nb, input int style);
    int s0, e0, lastCh, kind, dly;
    logic [75:0] ef;
    s0 = rx ? rxS : txS;
    e0 = rx ? rxE : txE;
    lastCh = rx ? LAST : 0;
    for (int b = 0; b <= nb; b++) begin
      for (int c = 0; c <= lastCh; c++) begin
        ef = expFrame(rx, b, c);
        waitValid("fv_rise");
        checkOutput("frame", frame_data, ef);
        checkOutput("bus_id", 76'(bus_id), 76'(b));
        checkOutput("adc_ch", 76'(adc_ch), 76'(c));
        repeat ($urandom_range(0, 2)) begin
          step();
          checkOutput("fv_hold", 76'(frame_valid), 76'(1));
          checkOutput("frame_hold", frame_data, ef);
        end
        // A bad response on the acceptance cycle must not be judged.
        frame_ready = 1'b1;
        resp_valid = 1'b1;
        resp_data = {8'(b), 4'd8, 8'h80, 56'd0};
        can_rec_select = 5'(b);
        step();
        frame_ready = 1'b0;
        resp_valid = 1'b0;
        checkOutput("fv_drop", 76'(frame_valid), 76'(0));
        kind = (style == 0) ? 0 : (style == 2) ? 4 : int'($urandom_range(0, 4));
        dly = (style == 0) ? 3 : int'($urandom_range(1, TMO));
        if (kind == 4) begin
          step(TMO);
          checkOutput("fv_wait", 76'(frame_valid), 76'(0));
        end else begin
          step(dly - 1);
          resp_data = {8'(b), 4'd8, 8'h43, 24'($urandom), 32'($urandom)};
          can_rec_select = 5'(b);
          case (kind)
            1: can_rec_select = 5'(b + 1 + int'($urandom_range(0, 30)));
            2: resp_data[63:56] = 8'h80;
            3: resp_data[75:68] = 8'(b + 32);
            default: ;
          endcase
          resp_valid = 1'b1;
          step();
          resp_valid = 1'b0;
        end
        if (kind != 0) expErr = (expErr < 255) ? expErr + 1 : 255;
        step();
        if (c < lastCh) begin
          checkOutput("next_ch_fv", 76'(frame_valid), 76'(1));
        end else if (b < nb) begin
          checkOutput("start_pulse", 76'(rx ? test_rx_start : test_tx_start), 76'(1));
          checkOutput("fv_gap", 76'(frame_valid), 76'(0));
        end else begin
          checkOutput("end_pulse", 76'(rx ? test_rx_end : test_tx_end), 76'(1));
        end
      end
    end
    checkOutput("err_cnt", 76'(err_cnt), 76'(expErr));
    step();
    checkOutput("start_cnt", 76'((rx ? rxS : txS) - s0), 76'(nb + 1));
    checkOutput("end_cnt", 76'((rx ? rxE : txE) - e0), 76'(1));
  endtask

  initial begin
    int f0, e0, nb;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_fv", 76'(frame_valid), 76'(0));
    checkOutput("rst_frame", frame_data, 76'(0));
    checkOutput("rst_bus", 76'(bus_id), 76'(0));
    checkOutput("rst_ch", 76'(adc_ch), 76'(0));
    checkOutput("rst_err", 76'(err_cnt), 76'(0));
    checkOutput("rst_tick", 76'(tick_mops), 76'(0));
    checkOutput("rst_pulses", 76'({test_rx_start, test_rx_end, test_tx_start, test_tx_end}), 76'(0));
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checkOutput("tick", 76'(tick_mops), 76'(k % DIV == 0));
    end

    // Requests without sign-on produce nothing.
    n_buses = 5'd15;
    test_tx = 1'b1;
    f0 = fvCnt;
    step(30);
    checkOutput("no_arm_fv", 76'(fvCnt - f0), 76'(0));
    armPulse();
    applyStimulus(1'b0, 15, 0);
    nb = int'($urandom_range(0, 7));
    n_buses = 5'(nb);
    applyStimulus(1'b0, nb, 1);
    test_tx = 1'b0;

    n_buses = 5'd1;
    test_rx = 1'b1;
    applyStimulus(1'b1, 1, 0);
    test_rx = 1'b0;
    step(3);
    nb = int'($urandom_range(0, 3));
    n_buses = 5'(nb);
    test_rx = 1'b1;
    test_tx = 1'b1;
    applyStimulus(1'b1, nb, 1);
    test_rx = 1'b0;
    test_tx = 1'b0;
    step(3);

    // Abort inside WAIT, then inside SEND; each abort disarms.
    n_buses = 5'd3;
    test_tx = 1'b1;
    waitValid("abort_fv");
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    step(2);
    f0 = fvCnt;
    e0 = txE;
    ext_rst_mops = 1'b1;
    step();
    ext_rst_mops = 1'b0;
    checkOutput("abort_wait_fv", 76'(frame_valid), 76'(0));
    step(30);
    checkOutput("abort_no_fv", 76'(fvCnt - f0), 76'(0));
    checkOutput("abort_no_end", 76'(txE - e0), 76'(0));
    checkOutput("abort_err_kept", 76'(err_cnt), 76'(expErr));
    armPulse();
    waitValid("rearm_fv");
    ext_rst_mops = 1'b1;
    step();
    ext_rst_mops = 1'b0;
    checkOutput("abort_send_fv", 76'(frame_valid), 76'(0));

    // Looping TX with no responder drives err_cnt into saturation.
    n_buses = 5'd31;
    armPulse();
    for (int p = 0; p < 10; p++) applyStimulus(1'b0, 31, 2);
    test_tx = 1'b0;
    checkOutput("err_sat", 76'(err_cnt), 76'(255));

    test_rx = 1'b1;
    waitValid("pre_rst_fv");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    expErr = 0;
    checkOutput("async_rst_fv", 76'(frame_valid), 76'(0));
    checkOutput("async_rst_frame", frame_data, 76'(0));
    checkOutput("async_rst_err", 76'(err_cnt), 76'(0));
    step();
    rst = 1'b0;
    f0 = fvCnt;
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("tick2", 76'(tick_mops), 76'(k % DIV == 0));
    end
    step(10);
    checkOutput("post_rst_disarmed", 76'(fvCnt - f0), 76'(0));
    test_rx = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mops_test_sequencer.md
# mops_test_sequencer

Synthesizable stimulus sequencer that replaces the behavioural data generator in hub-level MOPSHUB simulations and FPGA self-test builds. It steps through CAN buses 0..n_buses and issues SDO read-request frames toward the hub. For the RX test the frames are ADC channel reads; for the TX test they are device-type reads. It checks every response frame, counts errors, and provides a free-running divided clock-enable tick for MOPS emulation.

## Interface
Parameters:
- DIV, 4: divide ratio of tick_mops, ≥2.
- ADC_CH_LAST, 7: last ADC channel read per bus in the RX test (channels 0..ADC_CH_LAST).
- TIMEOUT, 1000: cycles to wait for a response before declaring an error.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- n_buses  in  5  index of the last bus tested; sampled at test start.
- start_data_gen  in  1  sign-on pulse; arms the sequencer.
- ext_rst_mops  in  1  synchronous abort: return to IDLE and disarm.
- test_rx  in  1  level; request RX test.
- test_tx  in  1  level; request TX test.
- frame_valid  out  1  request frame valid.
- frame_ready  in  1  hub accepts the frame.
- frame_data  out  76  request frame.
- resp_valid  in  1  one-cycle response strobe.
- resp_data  in  76  response frame (same format as frame_data).
- can_rec_select  in  5  bus on which the response arrived.
- bus_id  out  8  bus under test.
- adc_ch  out  6  channel under test (0 during TX test).
- test_rx_start, test_rx_end, test_tx_start, test_tx_end  out  1  one-cycle pulses.
- err_cnt  out  8  saturating error count.
- tick_mops  out  1  one-cycle pulse every DIV clocks.

## Operation
- Frame format: [75:68] bus_id; [67:64] DLC = 8; [63:0] payload bytes 0..7, with byte0 in [63:56].
- RX payload: 40 00 24 (adc_ch+1) 00 00 00 00, an SDO upload of index 0x2400 with subindex adc_ch+1.
- TX payload: 40 00 10 00 00 00 00 00, an SDO upload of index 0x1000.
- armed flag: set by start_data_gen; cleared by rst or ext_rst_mops.
- A test starts only when armed is set.
- States: IDLE, START, SEND, WAIT, NEXT, DONE.
- IDLE: when armed and test_rx=1, set mode=RX; otherwise, when armed and test_tx=1, set mode=TX. RX has priority over TX. Then latch n_buses, set bus_id=0 and adc_ch=0, and go to START.
- START: pulse test_rx_start or test_tx_start for the current bus, then go to SEND.
- SEND: assert frame_valid. Go to WAIT on the cycle with frame_valid && frame_ready. Clear the timeout counter.
- WAIT, response pass criteria: all three must hold.
  - resp_data[75:68] == bus_id
  - resp_data[63:56] == 8'h43
  - can_rec_select == bus_id[4:0]
- WAIT, outcomes:
  - resp_valid=1 and pass: go to NEXT.
  - resp_valid=1 and fail: err_cnt+1, then go to NEXT.
  - Counter reaches TIMEOUT−1 with no response: err_cnt+1, then go to NEXT.
- NEXT, RX mode: if adc_ch < ADC_CH_LAST, increment adc_ch and go to SEND. Otherwise set adc_ch=0 and advance the bus.
- NEXT, TX mode: advance the bus.
- Advancing the bus: if bus_id < latched n_buses, increment bus_id and go to START. Otherwise go to DONE.
- DONE: pulse test_rx_end or test_tx_end for the current mode, then go to IDLE.
  - A request still held high restarts a new pass, which gives looping TX.
- resp_valid outside WAIT is ignored.
- err_cnt saturates at 255 and is cleared only by rst.
- tick_mops comes from a counter running 0..DIV−1 and pulses when the counter equals DIV−1. It runs independently of the FSM, starting after reset release.

## Timing
- Reset values:
  - state = IDLE, armed = 0.
  - All outputs 0, including frame_data, bus_id, adc_ch, err_cnt and tick_mops.
  - Divider counter = 0.
- Arm to start: armed is set one cycle after start_data_gen. START is entered one cycle after IDLE sees armed together with a request. The start pulse is asserted in the START cycle.
- frame_valid rises one cycle after START and remains stable until frame_ready.
- frame_data changes only outside SEND.
- Response latency: minimum 1 cycle after acceptance.
- A resp_valid on the acceptance cycle itself is ignored.
- ext_rst_mops: deasserts frame_valid and goes to IDLE on the next edge without emitting an end pulse. err_cnt is kept.
- Simultaneous resp_valid and timeout in the same cycle: the response wins, and it is judged by the pass criteria.
- First tick_mops occurs DIV cycles after reset release, then every DIV cycles.

## Test plan
- Reset, then start_data_gen, then test_rx=1 with n_buses=1 and ADC_CH_LAST=1. A responder returns valid 43h frames 3 cycles after each acceptance. Required:
  - Frames go out for (bus,ch) = (0,0), (0,1), (1,0), (1,1).
  - Subindex bytes are 01, 02, 01, 02.
  - test_rx_start pulses twice and test_rx_end pulses once.
  - err_cnt = 0.
- test_tx=1 with n_buses=15 and no start_data_gen: no frame_valid ever appears. Then pulse start_data_gen: 16 frames with payload 40 00 10 00…, bus_id 0..15, then test_tx_end. test_tx held high makes the pass repeat.
- No responder and TIMEOUT=20 with a 1-bus, 1-channel RX test: WAIT lasts 20 cycles, err_cnt = 1, then test_rx_end.
- Response with can_rec_select ≠ bus_id, and separately with byte0 = 80h: err_cnt increments on each, and the sequence still advances.
- ext_rst_mops asserted in WAIT: IDLE next cycle, no end pulse, a new test requires a new start_data_gen. Also: 300 timeouts leave err_cnt = 255.
- DIV=4: tick_mops pulses at cycles 4, 8, 12… after reset release. Async rst mid-SEND clears frame_valid immediately.
